// File: rtl/serial_frame_pkg.sv
// Shared types and helpers for the serial frame receiver.
package serial_frame_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DATA   = 3'd1,
        S_PARITY = 3'd2,
        S_STOP   = 3'd3,
        S_BREAK  = 3'd4
    } rx_state_t;

    // Bit-counter width for a given payload width (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    // Expected parity bit for a zero-extended payload.
    function automatic logic exp_parity(input logic [31:0] payload, input logic odd);
        return (^payload) ^ odd;
    endfunction

endpackage

// File: rtl/frame_out_buf.sv
// One-entry valid/ready holding register; a load while full and not draining is dropped and flagged.
module frame_out_buf #(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         out_ready,
    output logic [W-1:0] dout,
    output logic         out_valid,
    output logic         overrun
);

    always_ff @(posedge clk) begin
        if (rst) begin
            dout      <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load) begin
                if (!out_valid || out_ready) begin
                    dout      <= din;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial-to-parallel frame receiver: start bit, LSB-first payload, optional parity, stop bit.
module serial_frame_rx
    import serial_frame_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter bit          PARITY_EN  = 1'b1,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              si,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int unsigned CNT_W = cnt_width(DATA_W);
    localparam int unsigned BUF_W = DATA_W + 2;

    rx_state_t          state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [DATA_W-1:0]  shreg;
    logic               p_bit;

    logic               complete;
    logic               perr_now;
    logic [BUF_W-1:0]   buf_din;
    logic [BUF_W-1:0]   buf_dout;

    always_comb begin
        complete = ce && (state == S_STOP);
        perr_now = PARITY_EN ? (p_bit != exp_parity(32'(shreg), PARITY_ODD)) : 1'b0;
        buf_din  = {~si, perr_now, shreg};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            p_bit   <= 1'b0;
        end else if (ce) begin
            case (state)
                S_IDLE: begin
                    if (!si) begin
                        state   <= S_DATA;
                        bit_cnt <= '0;
                    end
                end
                S_DATA: begin
                    shreg   <= {si, shreg[DATA_W-1:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        bit_cnt <= '0;
                        state   <= PARITY_EN ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    p_bit <= si;
                    state <= S_STOP;
                end
                S_STOP: begin
                    state <= si ? S_IDLE : S_BREAK;
                end
                S_BREAK: begin
                    // A held-low line must return high before another start bit counts.
                    if (si) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);

    frame_out_buf #(
        .W (BUF_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (complete),
        .din       (buf_din),
        .out_ready (out_ready),
        .dout      (buf_dout),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

    assign out_data   = buf_dout[DATA_W-1:0];
    assign parity_err = buf_dout[DATA_W];
    assign frame_err  = buf_dout[DATA_W+1];

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: directed frames plus randomized traffic against a frame-level model.
module tb_serial_frame_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic       si;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_frame_rx #(
        .DATA_W     (8),
        .PARITY_EN  (1'b1),
        .PARITY_ODD (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .si         (si),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    // Frame-level expectations handed from the stimulus to the model.
    logic       m_comp = 1'b0;
    logic [7:0] m_word = '0;
    logic       m_perr = 1'b0;
    logic       m_ferr = 1'b0;
    logic [7:0] p_word;
    logic       p_perr;
    logic       p_ferr;

    logic       mv = 1'b0;
    logic [7:0] md = '0;
    logic       mpe = 1'b0;
    logic       mfe = 1'b0;
    logic       mov = 1'b0;

    logic       rdy_fixed = 1'b0;
    logic       rdy_rand  = 1'b0;
    logic       cmp_en    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output buffer model driven by whole-frame completion events.
    always @(posedge clk) begin
        if (rst) begin
            mv = 1'b0; md = '0; mpe = 1'b0; mfe = 1'b0; mov = 1'b0;
        end else begin
            mov = m_comp && mv && !out_ready;
            if (m_comp && (!mv || out_ready)) begin
                mv = 1'b1; md = m_word; mpe = m_perr; mfe = m_ferr;
            end else if (out_ready) begin
                mv = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (cmp_en) begin
            #1;
            chk("out_valid", 32'(out_valid), 32'(mv));
            chk("out_data", 32'(out_data), 32'(md));
            chk("parity_err", 32'(parity_err), 32'(mpe));
            chk("frame_err", 32'(frame_err), 32'(mfe));
            chk("overrun", 32'(overrun), 32'(mov));
        end
    end

    task automatic drive_cycle(input logic c, input logic s, input logic comp, input logic ro);
        @(negedge clk);
        ce     = c;
        si     = s;
        m_comp = comp;
        if (comp) begin
            m_word = p_word;
            m_perr = p_perr;
            m_ferr = p_ferr;
        end
        out_ready = rdy_rand ? 1'($urandom % 2) : (ro ? 1'b1 : rdy_fixed);
    endtask

    task automatic strobe(input logic b, input int gap, input logic comp, input logic ro);
        for (int i = 1; i < gap; i++) drive_cycle(1'b0, 1'($urandom % 2), 1'b0, 1'b0);
        drive_cycle(1'b1, b, comp, ro);
    endtask

    task automatic idle(input int n, input int gap);
        for (int i = 0; i < n; i++) strobe(1'b1, gap, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] w, input logic pb, input logic stp,
                              input int gap, input logic stop_rdy);
        p_word = w;
        p_perr = (pb != 1'($countones(w) % 2));
        p_ferr = !stp;
        strobe(1'b0, gap, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) strobe(w[i], gap, 1'b0, 1'b0);
        strobe(pb, gap, 1'b0, 1'b0);
        strobe(stp, gap, 1'b1, stop_rdy);
    endtask

    task automatic settle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] w;
        logic       pb;
        logic       stp;
        int         gap;

        rst = 1'b1; ce = 1'b0; si = 1'b1; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        settle();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        cmp_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Basic frame: 0xA5, even parity bit 0.
        rdy_fixed = 1'b1;
        idle(2, 1);
        send_frame(8'hA5, 1'b0, 1'b1, 1, 1'b0);
        settle();
        chk("basic_valid", 32'(out_valid), 32'd1);
        chk("basic_data", 32'(out_data), 32'hA5);
        chk("basic_perr", 32'(parity_err), 32'd0);
        chk("basic_ferr", 32'(frame_err), 32'd0);
        idle(1, 1);
        settle();
        chk("basic_drop", 32'(out_valid), 32'd0);

        // Parity error.
        send_frame(8'h03, 1'b1, 1'b1, 1, 1'b0);
        settle();
        chk("par_data", 32'(out_data), 32'h03);
        chk("par_perr", 32'(parity_err), 32'd1);
        chk("par_ferr", 32'(frame_err), 32'd0);
        idle(2, 1);

        // Framing error followed by a held-low line.
        send_frame(8'h00, 1'b0, 1'b0, 1, 1'b0);
        settle();
        chk("brk_ferr", 32'(frame_err), 32'd1);
        chk("brk_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 20; i++) begin
            strobe(1'b0, 1, 1'b0, 1'b0);
            settle();
            chk("brk_busy", 32'(busy), 32'd1);
        end
        strobe(1'b1, 1, 1'b0, 1'b0);
        settle();
        chk("brk_exit_busy", 32'(busy), 32'd0);
        idle(1, 1);

        // Backpressure and overrun.
        rdy_fixed = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, 1, 1'b0);
        idle(1, 1);
        send_frame(8'h22, 1'b0, 1'b1, 1, 1'b0);
        settle();
        chk("ovr_pulse", 32'(overrun), 32'd1);
        chk("ovr_data", 32'(out_data), 32'h11);
        idle(1, 1);
        rdy_fixed = 1'b1;
        idle(1, 1);
        settle();
        chk("ovr_drain_valid", 32'(out_valid), 32'd0);
        chk("ovr_drain_data", 32'(out_data), 32'h11);

        // Accept coinciding with a completion.
        rdy_fixed = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, 1, 1'b0);
        idle(1, 1);
        send_frame(8'h22, 1'b0, 1'b1, 1, 1'b1);
        settle();
        chk("sim_valid", 32'(out_valid), 32'd1);
        chk("sim_data", 32'(out_data), 32'h22);
        chk("sim_overrun", 32'(overrun), 32'd0);
        rdy_fixed = 1'b1;
        idle(2, 1);

        // Sparse bit strobes, then reset mid-frame with a word still buffered.
        rdy_fixed = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b1, 3, 1'b0);
        settle();
        chk("ce_data", 32'(out_data), 32'h5A);
        chk("ce_valid", 32'(out_valid), 32'd1);
        strobe(1'b0, 1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) strobe(1'b1, 1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1; ce = 1'b1; si = 1'b1; m_comp = 1'b0;
        settle();
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rdy_fixed = 1'b1;
        idle(2, 1);
        send_frame(8'h3C, 1'b0, 1'b1, 1, 1'b0);
        settle();
        chk("post_rst_data", 32'(out_data), 32'h3C);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        idle(2, 1);

        // Randomized traffic.
        rdy_rand = 1'b1;
        for (int n = 0; n < 60; n++) begin
            w   = 8'($urandom);
            pb  = 1'($countones(w) % 2) ^ ($urandom % 4 == 0);
            stp = ($urandom % 7 != 0);
            gap = 1 + int'($urandom % 3);
            send_frame(w, pb, stp, gap, 1'b0);
            idle(stp ? int'($urandom % 3) : 1 + int'($urandom % 2), gap);
        end
        rdy_rand  = 1'b0;
        rdy_fixed = 1'b1;
        idle(3, 1);
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
Serial frame receiver that sits directly downstream of the serial shift-register stage and consumes its 1-bit output stream. It detects a start bit, shifts in DATA_W payload bits LSB-first, then checks an optional parity bit and the stop bit. Each received word goes to a one-entry output buffer with a valid/ready handshake. The block is the serial-to-parallel boundary of the serial datapath.

Parameters:
DATA_W, 8, payload width in bits (2..32)
PARITY_EN, 1, 1 = parity bit follows payload, 0 = no parity bit
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
ce  in  1  bit strobe; si sampled only on cycles with ce=1
si  in  1  serial input; line idles high
out_data  out  DATA_W  received payload
out_valid  out  1  out_data/status valid; held until accepted
out_ready  in  1  consumer accepts when out_valid && out_ready
parity_err  out  1  parity mismatch for the word in out_data
frame_err  out  1  stop bit was 0 for the word in out_data
overrun  out  1  one-cycle pulse: completed frame dropped because buffer full
busy  out  1  high in any state except IDLE

Behaviour:
- Reset: state=IDLE, bit_cnt=0, shreg=0. All outputs are 0. Reset mid-frame aborts the frame; nothing is delivered.
- ce=0 cycles: FSM, shreg and bit_cnt hold. The output handshake still operates every clk.
- FSM (advances only on ce=1):
  - IDLE: si=0 -> DATA, bit_cnt=0. si=1 -> stay.
  - DATA: shreg <= {si, shreg[DATA_W-1:1]}, bit_cnt++. When bit_cnt==DATA_W-1 -> PARITY if PARITY_EN, else STOP.
  - PARITY: capture p_bit -> STOP.
  - STOP: frame complete. si=1 -> IDLE with frame_err=0. si=0 -> BREAK with frame_err=1.
  - BREAK: stay until si=1 is sampled, then -> IDLE. This stops a held-low line from producing back-to-back zero frames.
- Parity check: expected = ^payload XOR PARITY_ODD. parity_err = (p_bit != expected). parity_err is always 0 when PARITY_EN=0.
- Completion event: the clk on which the STOP-state ce sample is taken.
- Output load on a completion event:
  - If !out_valid, or out_valid && out_ready in the same cycle: out_data, parity_err and frame_err load, and out_valid=1 from the next cycle.
  - Otherwise the new frame is dropped, the buffered word is unchanged, and overrun pulses for 1 cycle.
- Latency: out_valid rises 1 clk after the stop-bit sample.
- Accept without a completion: out_valid=0 next cycle. out_data, parity_err and frame_err hold their last values.
- Simultaneous accept and completion: out_valid stays 1 with the new word and no overrun.
- Minimum frame length: 1+DATA_W+PARITY_EN+1 ce strobes. Back-to-back frames are allowed; a start bit may immediately follow the stop bit.

Decomposition:
- Package serial_frame_pkg holds:
  - state encoding IDLE/DATA/PARITY/STOP/BREAK, 3 bits
  - localparam CNT_W = $clog2(DATA_W)
  - parity function
- One natural sub-module: frame_out_buf, the one-entry valid/ready holding register with overrun detect, parameterised on payload+status width.
- FSM and shifter stay in the top.

Test Plan (DATA_W=8, PARITY_EN=1, PARITY_ODD=0, ce=1 every cycle unless noted):
- Basic frame: si 0,1,0,1,0,0,1,0,1,0,1 with out_ready=1 -> out_data=0xA5, parity_err=0, frame_err=0, out_valid high 1 cycle, 1 clk after the stop sample.
- Parity error: frame 0x03 with parity bit 1 -> out_data=0x03, parity_err=1, frame_err=0.
- Framing/break: frame 0x00 with stop=0, then si held 0 for 20 cycles, then 1 -> one word with frame_err=1; busy stays 1 through BREAK; no further words until si returns high.
- Backpressure/overrun: out_ready=0, send 0x11 then 0x22 -> out_data stays 0x11, overrun pulses once at the 0x22 completion. Then out_ready=1 -> 0x11 accepted, out_valid=0.
- Simultaneous accept: hold 0x11 unaccepted and assert out_ready exactly at the 0x22 completion cycle -> out_valid stays 1, out_data=0x22, overrun=0.
- ce gating and reset: ce=1 every 3rd cycle, send 0x5A -> correct word. Then assert rst mid-payload of 0xFF -> busy=0 and out_valid=0 next cycle, no word delivered, and the next clean frame 0x3C is received correctly.
